// File: rtl/fifo_wr_arbiter_if.sv
// Bus between N write requesters, the arbiter and a downstream FIFO write port.
// Handshake: a word moves on a cycle where req_valid[i] && req_ready[i]; valid never waits on ready.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;
  logic                          dbg_state;
  logic [7:0]                    dbg_burst_cnt;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, dbg_state, dbg_burst_cnt
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, dbg_state, dbg_burst_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: one requester at a time owns the FIFO write port
// for up to MAX_BURST beats, with a single arbitration cycle between bursts.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input logic               clk,
  input logic               rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int         ID_W       = $clog2(NUM_REQ);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic [ID_W-1:0]   rr_pick;
  logic              rr_found;
  int                rr_idx;
  logic              grant_valid;
  logic              beat;
  logic [NUM_REQ-1:0] ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_q      <= '0;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Search starts just after the last winner, so every requester is reached within NUM_REQ grants.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_grant_q;
    rr_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!rr_found && bus.req_valid[rr_idx[ID_W-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    burst_cnt_d  = burst_cnt_q;
    ready        = '0;
    beat         = 1'b0;
    grant_valid  = bus.req_valid[grant_q];
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d      = BURST;
          grant_d      = rr_pick;
          last_grant_d = rr_pick;
          burst_cnt_d  = '0;
        end
      end
      BURST: begin
        ready[grant_q] = !bus.fifo_full;
        beat           = grant_valid && !bus.fifo_full;
        // A dropped valid ends the burst even while the FIFO is stalling it.
        if (!grant_valid) begin
          state_d = IDLE;
        end else if (beat) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (burst_cnt_d == BURST_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready     = ready;
  assign bus.fifo_wr_en    = beat;
  assign bus.fifo_wr_data  = beat ? bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.grant_id      = grant_q;
  assign bus.busy          = (state_q == BURST);
  assign bus.dbg_state     = (state_q == BURST);
  assign bus.dbg_burst_cnt = burst_cnt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run into a
// modelled 64-deep FIFO, all checked against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int MB = 8;
  localparam int FIFO_DEPTH = 64;
  localparam int WORDS = 100;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_owner;
  int m_beats;
  int m_last;
  int m_gid;

  int src_cnt[NR];
  int pop_seq[NR];
  int popped;
  bit fifo_mode;
  bit prev_busy;
  int grant_log[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int id, input int seq);
    return {4'(id), 12'(seq)};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = NR - 1;
    m_gid   = 0;
    prev_busy = 1'b0;
    exp_q.delete();
    grant_log.delete();
    for (int i = 0; i < NR; i++) src_cnt[i] = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 0);
    check({tag, "_wr_data"}, 32'(bus.fifo_wr_data), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.fifo_full = 1'b0;
    model_reset();
    #1;
    check_idle_outputs("reset");
    check("reset_grant_id", 32'(bus.grant_id), 0);
    check("reset_burst_cnt", 32'(bus.dbg_burst_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, check against the model, then advance model at posedge.
  task automatic cycle(input logic [NR-1:0] v, input logic full_in);
    logic            full;
    logic [NR-1:0]   e_ready;
    logic            e_wen;
    logic [DW-1:0]   e_data;
    logic [NR-1:0]   got_ready;
    logic            got_wen;
    logic [DW-1:0]   got_data;
    bit              found;
    int              r;
    logic [DW-1:0]   w;
    @(negedge clk);
    full = fifo_mode ? (fifo_q.size() >= FIFO_DEPTH) : full_in;
    bus.req_valid = v;
    bus.fifo_full = full;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = word_of(i, src_cnt[i]);
    #1;
    e_ready = '0;
    e_wen   = 1'b0;
    e_data  = '0;
    if (m_owner >= 0) begin
      if (!full) e_ready[m_owner] = 1'b1;
      if (!full && v[m_owner]) begin
        e_wen  = 1'b1;
        e_data = word_of(m_owner, src_cnt[m_owner]);
        exp_q.push_back(e_data);
      end
    end
    check("req_ready", 32'(bus.req_ready), 32'(e_ready));
    check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e_wen));
    check("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(e_data));
    check("busy", 32'(bus.busy), (m_owner >= 0) ? 1 : 0);
    check("grant_id", 32'(bus.grant_id), m_gid);
    check("burst_cnt", 32'(bus.dbg_burst_cnt), m_beats);
    if (fifo_mode) check("wr_while_full", 32'(bus.fifo_wr_en && full), 0);
    if (bus.fifo_wr_en) begin
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else check("wr_stream", 32'(bus.fifo_wr_data), 32'(exp_q.pop_front()));
    end
    if (bus.busy && !prev_busy) grant_log.push_back(int'(bus.grant_id));
    prev_busy = bus.busy;
    got_ready = bus.req_ready;
    got_wen   = bus.fifo_wr_en;
    got_data  = bus.fifo_wr_data;
    @(posedge clk);
    for (int i = 0; i < NR; i++) if (v[i] && got_ready[i]) src_cnt[i]++;
    if (fifo_mode) begin
      if (got_wen) fifo_q.push_back(got_data);
      if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        w = fifo_q.pop_front();
        r = int'(w[15:12]);
        if (r < NR) begin
          check("fifo_order", 32'(w[11:0]), pop_seq[r]);
          pop_seq[r]++;
        end else begin
          check("fifo_word_id", 32'(r), 0);
        end
        popped++;
      end
    end
    // model: arbitration, release on dropped valid, release after MB beats
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        r = (m_last + k) % NR;
        if (!found && v[r]) begin
          found   = 1'b1;
          m_owner = r;
          m_last  = r;
          m_gid   = r;
          m_beats = 0;
        end
      end
    end else if (!v[m_owner]) begin
      m_owner = -1;
    end else if (!full) begin
      m_beats++;
      if (m_beats == MB) m_owner = -1;
    end
  endtask

  initial begin
    logic [NR-1:0] v;
    int budget;
    bit all_sent;
    rst_n = 1'b0;
    fifo_mode = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    popped = 0;
    for (int i = 0; i < NR; i++) pop_seq[i] = 0;

    // single requester: 1 idle, 8 beats, 1 idle, 2 beats
    do_reset();
    for (int c = 0; c < 12; c++) cycle(4'b0010, 1'b0);
    check("single_word_count", 32'(src_cnt[1]), 10);

    // round robin with all requesters valid
    do_reset();
    for (int c = 0; c < 45; c++) cycle(4'hF, 1'b0);
    check("rr_bursts", 32'(grant_log.size()), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check($sformatf("rr_grant%0d", i), 32'(grant_log[i]), i % NR);

    // backpressure after beat 2 for three cycles
    do_reset();
    for (int c = 0; c < 3; c++) cycle(4'b0001, 1'b0);
    for (int c = 0; c < 3; c++) cycle(4'b0001, 1'b1);
    for (int c = 0; c < 7; c++) cycle(4'b0001, 1'b0);
    check("bp_burst_total", 32'(src_cnt[0]), 8);
    cycle(4'b0000, 1'b0);

    // early release: requester 2 drops after 3 beats while 3 waits
    do_reset();
    cycle(4'b0100, 1'b0);
    for (int c = 0; c < 3; c++) cycle(4'b1100, 1'b0);
    for (int c = 0; c < 3; c++) cycle(4'b1000, 1'b0);
    check("early_bursts", 32'(grant_log.size()), 2);
    if (grant_log.size() == 2) check("early_next_grant", 32'(grant_log[1]), 3);

    // asynchronous reset in the middle of a burst
    do_reset();
    for (int c = 0; c < 4; c++) cycle(4'hF, 1'b0);
    @(negedge clk);
    bus.req_valid = 4'hF;
    bus.fifo_full = 1'b0;
    #2;
    check("pre_reset_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    model_reset();
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) cycle(4'hF, 1'b0);
    check("post_reset_grants", 32'(grant_log.size()), 1);
    if (grant_log.size() > 0) check("post_reset_grant", 32'(grant_log[0]), 0);

    // randomized integration into a 64-deep FIFO
    do_reset();
    fifo_mode = 1'b1;
    fifo_q.delete();
    popped = 0;
    for (int i = 0; i < NR; i++) pop_seq[i] = 0;
    budget = 0;
    all_sent = 1'b0;
    while (!all_sent && budget < 20000) begin
      for (int i = 0; i < NR; i++) v[i] = (src_cnt[i] < WORDS) && ($urandom_range(0, 7) != 0);
      cycle(v, 1'b0);
      budget++;
      all_sent = 1'b1;
      for (int i = 0; i < NR; i++) if (src_cnt[i] < WORDS) all_sent = 1'b0;
    end
    check("send_timeout", 32'(all_sent), 1);
    budget = 0;
    while (fifo_q.size() > 0 && budget < 5000) begin
      cycle('0, 1'b0);
      budget++;
    end
    check("drain_timeout", 32'(fifo_q.size()), 0);
    check("words_popped", 32'(popped), NR * WORDS);
    for (int i = 0; i < NR; i++) check($sformatf("req%0d_words", i), 32'(pop_seq[i]), WORDS);
    check("exp_q_empty", 32'(exp_q.size()), 0);
    fifo_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
